// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one combinational add/mul/sub unit
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    input  logic [2*NREQ-1:0] req_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [7:0]        resp_result,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [1:0]        alu_op,
    input  logic [7:0]        alu_result
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] id_reg;
    logic [IDW-1:0] win;
    logic           found;
    logic [3:0]     a_arr  [NREQ];
    logic [3:0]     b_arr  [NREQ];
    logic [1:0]     op_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i]  = req_a[4*i +: 4];
            b_arr[i]  = req_b[4*i +: 4];
            op_arr[i] = req_op[2*i +: 2];
        end
    end

    // Scan starts just after the last winner so every requester gets a turn.
    always_comb begin : scan
        logic [IDW-1:0] cand;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = EXEC;
                    // Never advertise acceptance while reset is about to drop it.
                    req_ready[win] = !rst;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= IDW'(NREQ - 1);
            id_reg      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
        end else begin
            if (state == IDLE && found) begin
                alu_a      <= a_arr[win];
                alu_b      <= b_arr[win];
                alu_op     <= op_arr[win];
                id_reg     <= win;
                last_grant <= win;
            end
            if (state == EXEC) begin
                resp_result <= alu_result;
                resp_id     <= id_reg;
                resp_valid  <= 1'b1;
            end
            if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed checks of alu_share_arbiter against a behavioural model
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [2*NREQ-1:0] req_op;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [7:0]        resp_result;
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [1:0]        alu_op;
    logic [7:0]        alu_result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int grants[$];
    int gcyc[$];

    // Model state: phase 0 idle, 1 executing, 2 response pending.
    int         m_phase = 0;
    int         m_ptr   = NREQ - 1;
    int         m_id    = 0;
    logic [3:0] m_a     = '0;
    logic [3:0] m_b     = '0;
    logic [1:0] m_op    = '0;
    logic       m_rv    = 1'b0;
    logic [7:0] m_rid   = '0;
    logic [7:0] m_res   = '0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result)
    );

    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int x = int'(a);
        int y = int'(b);
        case (op)
            2'b00:   return 8'(x + y);
            2'b01:   return 8'(x - y);
            2'b10:   return 8'(x ^ y);
            default: return 8'(x * y);
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick();
        for (int k = 1; k <= NREQ; k++) begin
            int c = (m_ptr + k) % NREQ;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_all();
        logic [NREQ-1:0] er;
        int g;
        er = '0;
        g  = pick();
        if (!rst && m_phase == 0 && g >= 0) er = NREQ'(1) << g;
        check("req_ready",   32'(req_ready),   32'(er));
        check("resp_valid",  32'(resp_valid),  32'(m_rv));
        check("resp_id",     32'(resp_id),     32'(m_rid));
        check("resp_result", 32'(resp_result), 32'(m_res));
        check("alu_a",       32'(alu_a),       32'(m_a));
        check("alu_b",       32'(alu_b),       32'(m_b));
        check("alu_op",      32'(alu_op),      32'(m_op));
    endtask

    task automatic model_update();
        int g;
        if (rst) begin
            m_phase = 0; m_ptr = NREQ - 1; m_id = 0;
            m_a = '0; m_b = '0; m_op = '0;
            m_rv = 1'b0; m_rid = '0; m_res = '0;
        end else begin
            case (m_phase)
                0: begin
                    g = pick();
                    if (g >= 0) begin
                        m_a  = req_a[4*g +: 4];
                        m_b  = req_b[4*g +: 4];
                        m_op = req_op[2*g +: 2];
                        m_id = g;
                        m_ptr = g;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_res = alu_fn(m_a, m_b, m_op);
                    m_rid = 8'(m_id);
                    m_rv  = 1'b1;
                    m_phase = 2;
                end
                default: begin
                    if (resp_ready) begin
                        m_rv = 1'b0;
                        m_phase = 0;
                    end
                end
            endcase
        end
    endtask

    // One clock: compare outputs, record the observed grant, advance the model, move to next negedge.
    task automatic step();
        #1;
        check_all();
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    grants.push_back(i);
                    gcyc.push_back(cyc);
                end
            end
        end
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
        req_op[2*i +: 2] = op;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int expo[6];
        int n;
        expo[0] = 0; expo[1] = 1; expo[2] = 2; expo[3] = 3; expo[4] = 0; expo[5] = 1;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 1'b0;
        @(negedge clk);
        step();
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_alu_a", 32'(alu_a), 0);
        rst = 1'b0;

        // Single add on requester 0
        set_req(0, 4'd9, 4'd8, 2'b00);
        req_valid = 4'b0001;
        #1 check("add_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        step();
        check("add_valid", 32'(resp_valid), 1);
        check("add_id", 32'(resp_id), 0);
        check("add_result", 32'(resp_result), 17);
        resp_ready = 1'b1;
        step();
        check("add_cleared", 32'(resp_valid), 0);

        // Multiply on requester 2
        set_req(2, 4'd15, 4'd15, 2'b11);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        check("mul_id", 32'(resp_id), 2);
        check("mul_result", 32'(resp_result), 225);
        step();

        // Full load round robin
        do_reset();
        resp_ready = 1'b1;
        req_valid = 4'b1111;
        grants.delete();
        gcyc.delete();
        for (int i = 0; i < 18; i++) begin
            req_a = 16'($urandom); req_b = 16'($urandom); req_op = 8'($urandom);
            step();
        end
        check("rr_count", 32'(grants.size() >= 6), 1);
        n = (grants.size() < 6) ? grants.size() : 6;
        for (int i = 0; i < n; i++) begin
            check("rr_order", 32'(grants[i]), 32'(expo[i]));
            if (i > 0) check("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 3);
        end

        // Backpressure
        req_valid = '0; resp_ready = 1'b0;
        step();
        set_req(3, 4'd6, 4'd5, 2'b01);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        n = 0;
        while (!resp_valid && n < 10) begin
            step();
            n++;
        end
        check("bp_rise", 32'(resp_valid), 1);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(resp_valid), 1);
            check("bp_id", 32'(resp_id), 3);
            check("bp_result", 32'(resp_result), 1);
            check("bp_ready", 32'(req_ready), 0);
        end
        resp_ready = 1'b1;
        step();
        check("bp_release", 32'(resp_valid), 0);
        req_valid = '0;
        step();

        // Operand change after grant
        set_req(1, 4'd3, 4'd4, 2'b00);
        req_valid = 4'b0010;
        step();
        set_req(1, 4'd7, 4'd4, 2'b00);
        req_valid = '0;
        step();
        check("hold_id", 32'(resp_id), 1);
        check("hold_result", 32'(resp_result), 7);
        step();

        // Reset during EXEC
        set_req(0, 4'd2, 4'd3, 2'b11);
        req_valid = 4'b0001;
        step();
        rst = 1'b1;
        set_req(1, 4'd5, 4'd5, 2'b00);
        req_valid = 4'b0010;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(resp_valid), 0);
        #1 check("mid_rst_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        check("mid_rst_quiet", 32'(resp_valid), 0);
        step();
        check("post_rst_id", 32'(resp_id), 1);
        check("post_rst_result", 32'(resp_result), 10);
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            req_valid  = 4'($urandom);
            req_a      = 16'($urandom);
            req_b      = 16'($urandom);
            req_op     = 8'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
